// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA copy engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  // Bytes per word for a given data width; the address stride of every transfer.
  function automatic int bpw(input int data_width);
    return data_width / 8;
  endfunction

  // Stride for the default 32-bit word.
  localparam int BPW = bpw(32);

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with a fall-through head: head shows the oldest entry whenever
// empty is low. Pushes while full and pops while empty are ignored.
module dma_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; data is not reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dma_copy_engine.sv
// DMA copy engine: copies `length` words from the memory read port to the GLB
// write port. Optional macro DMA_ALIGN_CHECK_EN adds dma_err and rejects
// misaligned commands; without it, low address bits are floored to the word.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  dma_done,
  output logic                  dma_busy,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
`ifdef DMA_ALIGN_CHECK_EN
  ,
  output logic                  dma_err
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(bpw(DATA_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(bpw(DATA_WIDTH) - 1));

  dma_state_t            state, nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH:0]    len_ext;
  logic [LEN_WIDTH:0]    rd_cnt;
  logic [LEN_WIDTH:0]    wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  credit_ok;
  logic                  misaligned;
  logic                  start_ok;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  resp_ret;

  assign len_ext   = {1'b0, len_q};
  assign start_ok  = (state == IDLE) && dma_start;
  assign rd_fire   = rd_req_valid && rd_req_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign resp_ret  = rd_resp_valid && (outstanding != '0);
  // Reads in flight plus buffered words never exceed the FIFO, so a push can never overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

  assign rd_req_addr = rd_addr_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_valid ? fifo_head : '0;

`ifdef DMA_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = (|(src_addr & ~ALIGN_MASK)) || (|(dst_addr & ~ALIGN_MASK));
  assign dma_err    = (state == DONE) && err_q;

  // Remember whether the accepted command was rejected for alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_q <= 1'b0;
    else if (start_ok) err_q <= misaligned;
  end
`else
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nxt          = state;
    dma_done     = 1'b0;
    dma_busy     = 1'b0;
    rd_req_valid = 1'b0;
    wr_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (dma_start) nxt = ((length == '0) || misaligned) ? DONE : RUN;
      end
      RUN: begin
        dma_busy     = 1'b1;
        rd_req_valid = (rd_cnt < len_ext) && credit_ok;
        wr_valid     = !fifo_empty;
        if (!fifo_empty && wr_ready && (wr_cnt == len_ext - 1'b1)) nxt = DONE;
      end
      DONE: begin
        dma_done = 1'b1;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Command latch, address/count advance on each handshake, and read credit tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      outstanding <= '0;
    end else begin
      if (start_ok) begin
        len_q     <= length;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        rd_addr_q <= src_addr & ALIGN_MASK;
        wr_addr_q <= dst_addr & ALIGN_MASK;
      end else begin
        if (rd_fire) begin
          rd_addr_q <= rd_addr_q + STEP;
          rd_cnt    <= rd_cnt + 1'b1;
        end
        if (wr_fire) begin
          wr_addr_q <= wr_addr_q + STEP;
          wr_cnt    <= wr_cnt + 1'b1;
        end
      end
      case ({rd_fire, resp_ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  dma_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_resp_valid && !fifo_full),
    .push_data (rd_resp_data),
    .pop       (wr_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
